// File: rtl/mesh_router_param.sv
// Five-port mesh router: per-input FIFOs, XY/YX dimension-ordered routing,
// per-output round-robin arbitration with a registered output stage.
module mesh_router_param #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned COORD_WIDTH       = 2,
    parameter int unsigned MESH_X            = 4,
    parameter int unsigned MESH_Y            = 4,
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter int unsigned ROUTING_ALGORITHM = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COORD_WIDTH-1:0]  router_x,
    input  logic [COORD_WIDTH-1:0]  router_y,
    input  logic [5*DATA_WIDTH-1:0] in_packet,
    input  logic [4:0]              in_valid,
    output logic [4:0]              in_ready,
    output logic [5*DATA_WIDTH-1:0] out_packet,
    output logic [4:0]              out_valid,
    input  logic [4:0]              out_ready,
    output logic [15:0]             drop_count
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [2:0] PortN = 3'd0;
    localparam logic [2:0] PortS = 3'd1;
    localparam logic [2:0] PortE = 3'd2;
    localparam logic [2:0] PortW = 3'd3;
    localparam logic [2:0] PortL = 3'd4;

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
    endfunction

    logic [DATA_WIDTH-1:0]       fifo_mem_q [5][FIFO_DEPTH];
    logic [4:0][PtrW-1:0]        rd_ptr_q, wr_ptr_q;
    logic [4:0][CntW-1:0]        count_q;
    logic [4:0][DATA_WIDTH-1:0]  out_pkt_q;
    logic [4:0]                  out_valid_q;
    logic [4:0][2:0]             rr_ptr_q;
    logic [15:0]                 drop_count_q, drop_count_d;
    logic [16:0]                 drop_sum;

    logic [4:0]                  full, empty, push, pop, drop, grant_in, out_free;
    logic [4:0][DATA_WIDTH-1:0]  head;
    logic [4:0][COORD_WIDTH-1:0] dest_x, dest_y;
    logic [4:0][2:0]             route;
    logic [4:0][4:0]             req;  // req[output][input]
    logic [4:0]                  grant_valid;
    logic [4:0][2:0]             grant_idx;

    // FIFO status; in_ready is taken from registered occupancy only.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            full[i]     = (count_q[i] == CntW'(FIFO_DEPTH));
            empty[i]    = (count_q[i] == '0);
            in_ready[i] = !rst && !full[i];
            push[i]     = in_valid[i] && in_ready[i];
            head[i]     = fifo_mem_q[i][rd_ptr_q[i]];
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            dest_x[i] = head[i][DATA_WIDTH-1 -: COORD_WIDTH];
            dest_y[i] = head[i][DATA_WIDTH-1-COORD_WIDTH -: COORD_WIDTH];
            drop[i]   = !empty[i] && ((32'(dest_x[i]) >= MESH_X) || (32'(dest_y[i]) >= MESH_Y));
            route[i]  = PortL;
            if (ROUTING_ALGORITHM == 0) begin
                if      (dest_x[i] > router_x) route[i] = PortE;
                else if (dest_x[i] < router_x) route[i] = PortW;
                else if (dest_y[i] > router_y) route[i] = PortN;
                else if (dest_y[i] < router_y) route[i] = PortS;
            end else begin
                if      (dest_y[i] > router_y) route[i] = PortN;
                else if (dest_y[i] < router_y) route[i] = PortS;
                else if (dest_x[i] > router_x) route[i] = PortE;
                else if (dest_x[i] < router_x) route[i] = PortW;
            end
        end
    end

    always_comb begin
        req = '0;
        for (int i = 0; i < 5; i++) begin
            if (!empty[i] && !drop[i]) req[route[i]][i] = 1'b1;
        end
    end

    // Scan from the far end so the last hit is the first input at/after rr_ptr.
    always_comb begin
        grant_valid = '0;
        grant_idx   = '0;
        grant_in    = '0;
        out_free    = '0;
        for (int o = 0; o < 5; o++) begin
            out_free[o] = !out_valid_q[o] || out_ready[o];
            if (out_free[o]) begin
                for (int k = 4; k >= 0; k--) begin
                    if (req[o][wrap5({1'b0, rr_ptr_q[o]} + 4'(k))]) begin
                        grant_valid[o] = 1'b1;
                        grant_idx[o]   = wrap5({1'b0, rr_ptr_q[o]} + 4'(k));
                    end
                end
            end
            if (grant_valid[o]) grant_in[grant_idx[o]] = 1'b1;
        end
        pop = drop | grant_in;
    end

    always_comb begin
        drop_sum = {1'b0, drop_count_q};
        for (int i = 0; i < 5; i++) begin
            drop_sum = drop_sum + 17'(drop[i]);
        end
        drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (push[i]) fifo_mem_q[i][wr_ptr_q[i]] <= in_packet[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            out_pkt_q    <= '0;
            out_valid_q  <= '0;
            rr_ptr_q     <= '0;
            drop_count_q <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
                count_q[i] <= count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
            end
            for (int o = 0; o < 5; o++) begin
                if (out_free[o]) begin
                    if (grant_valid[o]) begin
                        out_pkt_q[o]   <= head[grant_idx[o]];
                        out_valid_q[o] <= 1'b1;
                        rr_ptr_q[o]    <= wrap5({1'b0, grant_idx[o]} + 4'd1);
                    end else begin
                        out_valid_q[o] <= 1'b0;
                    end
                end
            end
            drop_count_q <= drop_count_d;
        end
    end

    assign out_packet = out_pkt_q;
    assign out_valid  = out_valid_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_mesh_router_param.sv
// Directed bench for mesh_router_param: routing, XY/YX mode, contention,
// backpressure, drop counting with saturation, and mid-operation reset.
module tb_mesh_router_param;

    localparam int PN = 0, PS = 1, PE = 2, PW = 3, PL = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   router_x, router_y;
    logic [159:0] in_packet;
    logic [4:0]   in_valid, out_ready;

    logic [4:0]   in_ready, out_valid;
    logic [159:0] out_packet;
    logic [15:0]  drop_count;
    logic [4:0]   yx_in_ready, yx_out_valid;
    logic [159:0] yx_out_packet;
    logic [15:0]  yx_drop_count;
    logic [4:0]   m3_in_ready, m3_out_valid;
    logic [159:0] m3_out_packet;
    logic [15:0]  m3_drop_count;

    int n_checks = 0;
    int n_errors = 0;
    int acc, got, idx;
    logic rdy;
    logic [31:0] p;

    int rt_dx[5]   = '{3, 0, 1, 1, 1};
    int rt_dy[5]   = '{1, 1, 3, 0, 1};
    int rt_port[5] = '{PE, PW, PN, PS, PL};
    int cport[4]   = '{PN, PS, PW, PL};

    always #5 clk = ~clk;

    mesh_router_param dut (
        .clk(clk), .rst(rst), .router_x(router_x), .router_y(router_y),
        .in_packet(in_packet), .in_valid(in_valid), .in_ready(in_ready),
        .out_packet(out_packet), .out_valid(out_valid), .out_ready(out_ready),
        .drop_count(drop_count)
    );

    mesh_router_param #(.ROUTING_ALGORITHM(1)) dut_yx (
        .clk(clk), .rst(rst), .router_x(router_x), .router_y(router_y),
        .in_packet(in_packet), .in_valid(in_valid), .in_ready(yx_in_ready),
        .out_packet(yx_out_packet), .out_valid(yx_out_valid), .out_ready(out_ready),
        .drop_count(yx_drop_count)
    );

    mesh_router_param #(.MESH_X(3)) dut_m3 (
        .clk(clk), .rst(rst), .router_x(router_x), .router_y(router_y),
        .in_packet(in_packet), .in_valid(in_valid), .in_ready(m3_in_ready),
        .out_packet(m3_out_packet), .out_valid(m3_out_valid), .out_ready(out_ready),
        .drop_count(m3_drop_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_pkt(input logic [1:0] x, input logic [1:0] y,
                                           input logic [27:0] pl);
        return {x, y, pl};
    endfunction

    function automatic logic [31:0] bp_pkt(input int n);
        return mk_pkt(2'd3, 2'd1, 28'h0B00000 + 28'(n));
    endfunction

    task automatic do_reset();
        in_valid  = '0;
        in_packet = '0;
        out_ready = 5'b11111;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = '0; in_packet = '0; out_ready = 5'b11111;
        router_x = 2'd1; router_y = 2'd1;

        // Reset state
        @(posedge clk); #1;
        check("rst_in_ready_low", in_ready, 5'b0);
        check("rst_out_valid", out_valid, 5'b0);
        check("rst_out_packet", out_packet, 160'b0);
        check("rst_drop_count", drop_count, 16'h0);
        rst = 1'b0;
        #1;
        check("rst_in_ready_high", in_ready, 5'b11111);

        // Routing from L at router (1,1), XY
        for (int i = 0; i < 5; i++) begin
            p = mk_pkt(2'(rt_dx[i]), 2'(rt_dy[i]), 28'h5A5A000 + 28'(i));
            in_packet[PL*32 +: 32] = p;
            in_valid[PL] = 1'b1;
            @(posedge clk); #1;
            in_valid[PL] = 1'b0;
            check($sformatf("route%0d_lat1", i), out_valid, 5'b0);
            @(posedge clk); #1;
            check($sformatf("route%0d_valid", i), out_valid, 5'b1 << rt_port[i]);
            check($sformatf("route%0d_data", i), out_packet[rt_port[i]*32 +: 32], p);
            @(posedge clk); #1;
        end

        // XY vs YX: dest (3,3) on W
        p = mk_pkt(2'd3, 2'd3, 28'h0C0FFEE);
        in_packet[PW*32 +: 32] = p;
        in_valid[PW] = 1'b1;
        @(posedge clk); #1;
        in_valid[PW] = 1'b0;
        @(posedge clk); #1;
        check("mode_xy_valid", out_valid, 5'b00100);
        check("mode_xy_data", out_packet[PE*32 +: 32], p);
        check("mode_yx_valid", yx_out_valid, 5'b00001);
        check("mode_yx_data", yx_out_packet[PN*32 +: 32], p);
        @(posedge clk); #1;

        // Contention: N, S, W, L all to E, three packets each
        do_reset();
        for (int j = 0; j < 4; j++)
            in_packet[cport[j]*32 +: 32] = mk_pkt(2'd3, 2'd1, {20'h0, 4'(cport[j]), 4'd0});
        in_valid = 5'b11011;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (c < 2) begin
                for (int j = 0; j < 4; j++)
                    in_packet[cport[j]*32 +: 32] =
                        mk_pkt(2'd3, 2'd1, {20'h0, 4'(cport[j]), 4'(c + 1)});
            end else if (c == 2) begin
                in_valid = '0;
            end
            if (c >= 1 && c <= 12) begin
                idx = c - 1;
                check($sformatf("cont%0d_valid", idx), out_valid[PE], 1'b1);
                check($sformatf("cont%0d_data", idx), out_packet[PE*32 +: 32],
                      mk_pkt(2'd3, 2'd1, {20'h0, 4'(cport[idx % 4]), 4'(idx / 4)}));
            end
        end
        check("cont_idle", out_valid, 5'b0);

        // Backpressure on E while W sends 6 packets
        do_reset();
        out_ready[PE] = 1'b0;
        acc = 0;
        in_packet[PW*32 +: 32] = bp_pkt(0);
        in_valid[PW] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rdy = in_ready[PW];
            @(posedge clk); #1;
            if (rdy && in_valid[PW]) acc++;
            in_valid[PW] = (acc < 6);
            in_packet[PW*32 +: 32] = bp_pkt(acc);
            if (c >= 1) begin
                check($sformatf("bp_hold%0d", c), {out_valid[PE], out_packet[PE*32 +: 32]},
                      {1'b1, bp_pkt(0)});
            end
        end
        check("bp_accepted", 64'(acc), 64'd5);
        check("bp_in_ready_low", in_ready[PW], 1'b0);
        out_ready[PE] = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            rdy = in_ready[PW];
            if (out_valid[PE]) begin
                check($sformatf("bp_order%0d", got), out_packet[PE*32 +: 32], bp_pkt(got));
                got++;
            end
            @(posedge clk); #1;
            if (rdy && in_valid[PW]) acc++;
            in_valid[PW] = (acc < 6);
            in_packet[PW*32 +: 32] = bp_pkt(acc);
        end
        in_valid = '0;
        check("bp_delivered", 64'(got), 64'd6);

        // Drop with MESH_X=3: two heads dropped in one cycle
        do_reset();
        in_packet[PN*32 +: 32] = mk_pkt(2'd3, 2'd0, 28'h0D0D001);
        in_packet[PS*32 +: 32] = mk_pkt(2'd3, 2'd0, 28'h0D0D002);
        in_valid = 5'b00011;
        @(posedge clk); #1;
        in_valid = '0;
        check("drop_cnt_before", m3_drop_count, 16'd0);
        @(posedge clk); #1;
        check("drop_cnt_two", m3_drop_count, 16'd2);
        check("drop_no_valid", m3_out_valid, 5'b0);
        check("drop_fifos_empty", m3_in_ready, 5'b11111);
        @(posedge clk); #1;
        check("drop_no_valid_late", m3_out_valid, 5'b0);

        // Saturation: 2 + 5*13106 = 65532, then one more burst of 5 saturates
        for (int j = 0; j < 5; j++) in_packet[j*32 +: 32] = mk_pkt(2'd3, 2'd2, 28'(j));
        in_valid = 5'b11111;
        repeat (13106) @(posedge clk);
        #1;
        in_valid = '0;
        @(posedge clk); #1;
        check("drop_cnt_near_max", m3_drop_count, 16'hFFFC);
        in_valid = 5'b11111;
        @(posedge clk); #1;
        in_valid = '0;
        @(posedge clk); #1;
        check("drop_cnt_saturate", m3_drop_count, 16'hFFFF);
        in_valid = 5'b11111;
        repeat (5) @(posedge clk);
        #1;
        in_valid = '0;
        @(posedge clk); #1;
        check("drop_cnt_stay_sat", m3_drop_count, 16'hFFFF);

        // Reset mid-operation: N output held, three packets buffered on L
        do_reset();
        out_ready[PN] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_packet[PL*32 +: 32] = mk_pkt(2'd1, 2'd3, 28'h0E00000 + 28'(k));
            in_valid[PL] = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = '0;
        check("mid_pre_valid", out_valid, 5'b00001);
        check("mid_pre_in_ready", in_ready, 5'b11111);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 5'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_out_valid", out_valid, 5'b0);
        check("mid_in_ready", in_ready, 5'b11111);
        check("mid_drop_count", drop_count, 16'h0);
        check("mid_out_packet", out_packet, 160'b0);
        out_ready = 5'b11111;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("mid_no_stale%0d", c), out_valid, 5'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
